// File: rtl/cp0_exc_redirect_pkg.sv
// Shared constants and state encoding for the CP0 exception/ERET redirect controller.
package cp0_exc_redirect_pkg;

   localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC00380;
   localparam int          FLUSH_CYCLES_DEF = 2;
   localparam int          CNT_W            = 4;

   typedef enum logic [1:0] {
      REDIR_IDLE  = 2'd0,
      REDIR_FLUSH = 2'd1,
      REDIR_WAIT  = 2'd2
   } redir_state_t;

endpackage

// File: rtl/cp0_exc_redirect.sv
// Exception/ERET redirect controller: flushes the pipeline for a fixed count,
// then offers the redirect PC to fetch over a valid/ready handshake.
//
// state       | meaning
// ------------+---------------------------------------------------------
// REDIR_IDLE  | waiting for an exception or ERET from writeback
// REDIR_FLUSH | pipeline flush, down-counter running to terminal count 0
// REDIR_WAIT  | redirect offered to fetch, held until redirect_ready
module cp0_exc_redirect
   import cp0_exc_redirect_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter int          FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exception,
   input  logic        eret,
   input  logic        EXL,
   input  logic [31:0] cp0_EPC_data,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        exl_set,
   output logic        exl_clr,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

   redir_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      pc_nxt;
   logic             flush_nxt, valid_nxt, set_nxt, clr_nxt, busy_nxt;

   // Nested exceptions still vector to EXC_VECTOR, so EXL never alters the target.
   logic unused_exl;
   assign unused_exl = EXL;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_nxt    = redirect_pc;
      flush_nxt = flush;
      valid_nxt = redirect_valid;
      set_nxt   = 1'b0;
      clr_nxt   = 1'b0;
      case (state)
         REDIR_IDLE: begin
            if (exception) begin
               state_nxt = REDIR_FLUSH;
               cnt_nxt   = CNT_INIT;
               pc_nxt    = EXC_VECTOR;
               flush_nxt = 1'b1;
               set_nxt   = 1'b1;
            end else if (eret) begin
               state_nxt = REDIR_FLUSH;
               cnt_nxt   = CNT_INIT;
               pc_nxt    = cp0_EPC_data;
               flush_nxt = 1'b1;
               clr_nxt   = 1'b1;
            end
         end
         REDIR_FLUSH: begin
            if (cnt == '0) begin
               state_nxt = REDIR_WAIT;
               valid_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         REDIR_WAIT: begin
            if (redirect_ready) begin
               state_nxt = REDIR_IDLE;
               flush_nxt = 1'b0;
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = REDIR_IDLE;
            flush_nxt = 1'b0;
            valid_nxt = 1'b0;
         end
      endcase
      busy_nxt = (state_nxt != REDIR_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= REDIR_IDLE;
         cnt            <= '0;
         redirect_pc    <= 32'h0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         exl_set        <= 1'b0;
         exl_clr        <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         redirect_pc    <= pc_nxt;
         flush          <= flush_nxt;
         redirect_valid <= valid_nxt;
         exl_set        <= set_nxt;
         exl_clr        <= clr_nxt;
         busy           <= busy_nxt;
      end
   end

endmodule
